// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM encoding and helpers for the ALU scheduler
package alu_pkg;

    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] ADD  = 4'd0;
    localparam logic [OPCODE_W-1:0] SUB  = 4'd1;
    localparam logic [OPCODE_W-1:0] MUL  = 4'd2;
    localparam logic [OPCODE_W-1:0] SLTU = 4'd3;
    localparam logic [OPCODE_W-1:0] XOR  = 4'd4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // Only add/subtract produce a meaningful carry (borrow for SUB).
    function automatic logic is_carry_op(input logic [OPCODE_W-1:0] op);
        return (op == ADD) || (op == SUB);
    endfunction

endpackage

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// rtl/alu_rr_scheduler_rr_arbiter.sv - combinational round-robin arbiter
//
// Ports:
//   req_i       : per-requester request bits
//   ptr_i       : highest-priority requester index this cycle
//   grant_o     : one-hot grant (zero when nothing requests)
//   grant_idx_o : index of the granted requester (0 when nothing requests)
//   any_grant_o : a grant was made
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o,
    output logic               any_grant_o
);

    int idx;

    // Scan ptr, ptr+1, ... wrapping; the first requester found wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (!any_grant_o && req_i[idx]) begin
                any_grant_o  = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - round-robin sharing of one pipelined ALU with ID-tagged responses
//
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready : per-requester handshake, at most one ready bit high
//   req_opcode/a/b      : packed per-requester operation fields
//   alu_opcode/in1/in2  : drive to the shared ALU (zero when nothing issues)
//   alu_result/carry    : ALU outputs, ALU_LATENCY cycles after issue
//   rsp_valid/id/result/carry : one-cycle response pulse with owner ID
//   halt_req/halted     : quiesce handshake (RUN -> DRAIN -> HALTED)
//   issue_count         : wrapping count of issued operations
module alu_rr_scheduler
    import alu_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 8,
    parameter int ALU_LATENCY = 2,
    parameter int ID_W        = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [4*NUM_REQ-1:0]    req_opcode,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic [OPCODE_W-1:0]     alu_opcode,
    output logic [WIDTH-1:0]        alu_in1,
    output logic [WIDTH-1:0]        alu_in2,
    input  logic [WIDTH-1:0]        alu_result,
    input  logic                    alu_carry,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [WIDTH-1:0]        rsp_result,
    output logic                    rsp_carry,
    input  logic                    halt_req,
    output logic                    halted,
    output logic [15:0]             issue_count
);

    localparam int LAST = ALU_LATENCY - 1;

    state_e                             state_q, state_d;
    logic [ID_W-1:0]                    rr_ptr_q, rr_ptr_d;
    logic [15:0]                        issue_count_q, issue_count_d;
    logic [ALU_LATENCY-1:0]             tag_vld_q, tag_vld_d;
    logic [ALU_LATENCY-1:0][ID_W-1:0]   tag_id_q, tag_id_d;
    logic [ALU_LATENCY-1:0]             tag_cen_q, tag_cen_d;

    logic [NUM_REQ-1:0] grant_oh;
    logic [ID_W-1:0]    grant_idx;
    logic               any_grant;
    logic               issue_en;
    logic               handshake;
    logic [31:0]        sel;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant_oh),
        .grant_idx_o (grant_idx),
        .any_grant_o (any_grant)
    );

    assign sel = 32'(grant_idx);

    // FSM next state and issue permission. halt_req blocks grants in the
    // very cycle it rises so nothing new enters the pipe while draining.
    always_comb begin
        state_d  = state_q;
        issue_en = 1'b0;
        halted   = 1'b0;
        case (state_q)
            ST_RUN: begin
                issue_en = !halt_req && !rst;
                if (halt_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (tag_vld_d == '0) state_d = ST_HALTED;
            end
            ST_HALTED: begin
                halted = 1'b1;
                if (!halt_req) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign req_ready = issue_en ? grant_oh : '0;
    assign handshake = issue_en && any_grant;

    // Datapath: ALU drive, pointer, counter and tag pipeline.
    always_comb begin
        alu_opcode    = '0;
        alu_in1       = '0;
        alu_in2       = '0;
        rr_ptr_d      = rr_ptr_q;
        issue_count_d = issue_count_q;
        if (handshake) begin
            alu_opcode    = req_opcode[sel*OPCODE_W +: OPCODE_W];
            alu_in1       = req_a[sel*WIDTH +: WIDTH];
            alu_in2       = req_b[sel*WIDTH +: WIDTH];
            rr_ptr_d      = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
            issue_count_d = issue_count_q + 16'd1;
        end

        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_cen_d    = '0;
        tag_vld_d[0] = handshake;
        tag_id_d[0]  = grant_idx;
        tag_cen_d[0] = is_carry_op(alu_opcode);
        for (int s = 1; s < ALU_LATENCY; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
            tag_cen_d[s] = tag_cen_q[s-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            rr_ptr_q      <= '0;
            issue_count_q <= '0;
            tag_vld_q     <= '0;
            tag_id_q      <= '0;
            tag_cen_q     <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            issue_count_q <= issue_count_d;
            tag_vld_q     <= tag_vld_d;
            tag_id_q      <= tag_id_d;
            tag_cen_q     <= tag_cen_d;
        end
    end

    // Result and carry are gated by the tag so idle ALU outputs never leak.
    assign rsp_valid   = tag_vld_q[LAST];
    assign rsp_id      = tag_id_q[LAST];
    assign rsp_result  = tag_vld_q[LAST] ? alu_result : '0;
    assign rsp_carry   = tag_vld_q[LAST] & tag_cen_q[LAST] & alu_carry;
    assign issue_count = issue_count_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb/tb_alu_rr_scheduler.sv - scoreboard bench for alu_rr_scheduler
module tb_alu_rr_scheduler;
    import alu_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [4*NUM_REQ-1:0]     req_opcode;
    logic [WIDTH*NUM_REQ-1:0] req_a;
    logic [WIDTH*NUM_REQ-1:0] req_b;
    logic [3:0]               alu_opcode;
    logic [WIDTH-1:0]         alu_in1, alu_in2, alu_result;
    logic                     alu_carry;
    logic                     rsp_valid;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_result;
    logic                     rsp_carry;
    logic                     halt_req;
    logic                     halted;
    logic [15:0]              issue_count;

    always #5 clk = ~clk;

    alu_rr_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ALU_LATENCY(2), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
        .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .halt_req(halt_req), .halted(halted), .issue_count(issue_count)
    );

    // Two-stage ALU model; carry is the 9th result bit (borrow for SUB, high product for MUL).
    function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] m;
        m = 16'(a) * 16'(b);
        case (op)
            ADD:     return {1'b0, a} + {1'b0, b};
            SUB:     return {1'b0, a} - {1'b0, b};
            MUL:     return {|m[15:8], m[7:0]};
            SLTU:    return {8'd0, a < b};
            XOR:     return {1'b0, a ^ b};
            default: return 9'd0;
        endcase
    endfunction

    logic [8:0] p1, p2;
    always @(posedge clk) begin
        p1 <= alu_f(alu_opcode, alu_in1, alu_in2);
        p2 <= p1;
    end
    assign alu_result = p2[7:0];
    assign alu_carry  = p2[8];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int         due;
        logic [1:0] id;
        logic [7:0] res;
        logic       c;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] exp_count = 16'd0;

    task automatic push_exp(input logic [1:0] id, input logic [7:0] r, input logic c);
        exp_t e;
        e.due = cyc + 2;
        e.id  = id;
        e.res = r;
        e.c   = c;
        sb.push_back(e);
        exp_count = exp_count + 16'd1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() > 0 && sb[0].due < cyc) begin
                chk("rsp_missing", {31'b0, rsp_valid}, 32'd1);
                void'(sb.pop_front());
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", {31'b0, rsp_valid}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_cycle", cyc, mon_e.due);
                    chk("rsp_id", {30'b0, rsp_id}, {30'b0, mon_e.id});
                    chk("rsp_result", {24'b0, rsp_result}, {24'b0, mon_e.res});
                    chk("rsp_carry", {31'b0, rsp_carry}, {31'b0, mon_e.c});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        req_valid[i]        = 1'b1;
        req_opcode[4*i +: 4] = op;
        req_a[8*i +: 8]      = a;
        req_b[8*i +: 8]      = b;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {28'b0, req_ready}, 32'd0);
        chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_id"}, {30'b0, rsp_id}, 32'd0);
        chk({tag, "_rsp_result"}, {24'b0, rsp_result}, 32'd0);
        chk({tag, "_rsp_carry"}, {31'b0, rsp_carry}, 32'd0);
        chk({tag, "_halted"}, {31'b0, halted}, 32'd0);
        chk({tag, "_count"}, {16'b0, issue_count}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; halt_req = 1'b0;
        req_valid = '0; req_opcode = '0; req_a = '0; req_b = '0;
        repeat (2) tick();

        // Reset state, with requests pending to show ready stays low.
        req_valid = 4'b1111; #1;
        check_reset_outputs("reset");
        req_valid = '0;
        rst = 1'b0;
        tick();

        // Single ADD from requester 1.
        set_req(1, ADD, 8'hF0, 8'h20); #1;
        chk("single_ready", {28'b0, req_ready}, 32'h2);
        push_exp(2'd1, 8'h10, 1'b1);
        tick();
        req_valid = '0;
        chk("single_count", {16'b0, issue_count}, 32'd1);
        repeat (3) tick();

        // Fairness from reset: all four XOR i,0xFF.
        rst = 1'b1; tick(); rst = 1'b0; exp_count = 16'd0;
        for (int i = 0; i < 4; i++) set_req(i, XOR, 8'(i), 8'hFF);
        for (int n = 0; n < 8; n++) begin
            #1;
            chk("fair_ready", {28'b0, req_ready}, 32'(1 << (n % 4)));
            if (n >= 2) chk("fair_rsp_cont", {31'b0, rsp_valid}, 32'd1);
            push_exp(2'(n % 4), 8'(n % 4) ^ 8'hFF, 1'b0);
            tick();
        end
        req_valid = '0;
        repeat (3) tick();
        chk("fair_count", {16'b0, issue_count}, 32'd8);

        // Carry masking: SUB borrow passes, MUL carry is masked.
        set_req(0, SUB, 8'h05, 8'h07); #1;
        chk("sub_ready", {28'b0, req_ready}, 32'h1);
        push_exp(2'd0, 8'hFE, 1'b1);
        tick();
        set_req(0, MUL, 8'h10, 8'h10); #1;
        chk("mul_ready", {28'b0, req_ready}, 32'h1);
        push_exp(2'd0, 8'h00, 1'b0);
        tick();
        req_valid = '0;
        repeat (3) tick();

        // Halt/drain: request in the halt_req cycle is not granted.
        set_req(1, ADD, 8'h01, 8'h02); #1;
        chk("halt_c_ready", {28'b0, req_ready}, 32'h2);
        push_exp(2'd1, 8'h03, 1'b0);
        tick();
        req_valid = '0;
        set_req(2, ADD, 8'h03, 8'h04);
        halt_req = 1'b1; #1;
        chk("halt_c1_ready", {28'b0, req_ready}, 32'h0);
        tick();
        chk("halt_c2_halted", {31'b0, halted}, 32'd0);
        chk("halt_c2_ready", {28'b0, req_ready}, 32'h0);
        tick();
        chk("halt_c3_halted", {31'b0, halted}, 32'd1);
        chk("halt_c3_ready", {28'b0, req_ready}, 32'h0);
        tick();
        chk("halt_c4_halted", {31'b0, halted}, 32'd1);
        halt_req = 1'b0; #1;
        chk("halt_release_ready", {28'b0, req_ready}, 32'h0);
        tick();
        chk("resume_halted", {31'b0, halted}, 32'd0);
        chk("resume_ready", {28'b0, req_ready}, 32'h4);
        push_exp(2'd2, 8'h07, 1'b0);
        tick();
        req_valid = '0;
        repeat (3) tick();
        chk("halt_count", {16'b0, issue_count}, {16'b0, exp_count});

        // Reset mid-flight: the MUL is dropped.
        set_req(1, MUL, 8'h03, 8'h05); #1;
        chk("mid_ready", {28'b0, req_ready}, 32'h2);
        tick();
        req_valid = '0;
        rst = 1'b1; #1;
        check_reset_outputs("mid_reset");
        tick();
        chk("mid_no_rsp", {31'b0, rsp_valid}, 32'd0);
        exp_count = 16'd0;
        set_req(0, ADD, 8'h01, 8'h01);
        set_req(2, ADD, 8'h02, 8'h02); #1;
        chk("mid_rst_ready", {28'b0, req_ready}, 32'h0);
        tick();
        rst = 1'b0; #1;
        chk("post_rst_grant0", {28'b0, req_ready}, 32'h1);
        push_exp(2'd0, 8'h02, 1'b0);
        tick();
        req_valid[0] = 1'b0; #1;
        chk("post_rst_grant2", {28'b0, req_ready}, 32'h4);
        push_exp(2'd2, 8'h04, 1'b0);
        tick();
        req_valid = '0;

        // Unused opcode 9 and SLTU: issued normally, carry masked.
        set_req(3, 4'd9, 8'h12, 8'h34); #1;
        chk("op9_ready", {28'b0, req_ready}, 32'h8);
        push_exp(2'd3, 8'h00, 1'b0);
        tick();
        req_valid = '0;
        set_req(0, SLTU, 8'h03, 8'h05); #1;
        chk("sltu_ready", {28'b0, req_ready}, 32'h1);
        push_exp(2'd0, 8'h01, 1'b0);
        tick();
        req_valid = '0;
        repeat (3) tick();
        chk("pre_wrap_count", {16'b0, issue_count}, 32'd4);

        // Counter wrap: issue until 0xFFFF, then one more.
        set_req(3, XOR, 8'h00, 8'h00);
        while (exp_count != 16'hFFFF) begin
            push_exp(2'd3, 8'h00, 1'b0);
            tick();
        end
        chk("count_ffff", {16'b0, issue_count}, 32'h0000FFFF);
        push_exp(2'd3, 8'h00, 1'b0);
        tick();
        req_valid = '0;
        chk("count_wrap", {16'b0, issue_count}, 32'd0);
        repeat (4) tick();
        chk("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
